// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: ALU widths, opcode encodings and
// the scheduler FSM state type.
package alu_arb_pkg;

    localparam int ALU_DW = 4;   // ALU operand width
    localparam int ALU_OW = 8;   // ALU result width
    localparam int SEL_W  = 3;   // ALU opcode width

    localparam logic [SEL_W-1:0] OP_ADD = 3'b000;
    localparam logic [SEL_W-1:0] OP_SUB = 3'b001;
    localparam logic [SEL_W-1:0] OP_MUL = 3'b010;
    localparam logic [SEL_W-1:0] OP_AND = 3'b011;
    localparam logic [SEL_W-1:0] OP_OR  = 3'b100;
    localparam logic [SEL_W-1:0] OP_NOT = 3'b101;
    localparam logic [SEL_W-1:0] OP_INC = 3'b110;
    localparam logic [SEL_W-1:0] OP_DEC = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches req upward from last_grant+1
// with wrap-around and returns the first requester found, both as a one-hot
// vector and as an index. Outputs are zero when no request is present.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [ID_W-1:0]    grant_idx
);

    int   cand;
    logic found;

    // Rotating priority search; the first hit after last_grant wins.
    always_comb begin
        // NOTE: every variable written here gets a default first so no path
        // leaves one unassigned, which would infer a latch.
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        cand         = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(last_grant) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[cand[ID_W-1:0]]) begin
                found                           = 1'b1;
                grant_onehot[cand[ID_W-1:0]]    = 1'b1;
                grant_idx                       = cand[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin scheduler sharing one combinational ALU among NUM_REQ
// requesters. One operation is in flight at a time: grant in IDLE, one EXEC
// cycle with registered ALU operands, then the captured result is held in
// RESP until the consumer accepts it.
// Optional macro ALU_ARB_STATS_EN adds a saturating completed-operation
// counter on port op_count.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
`ifdef ALU_ARB_STATS_EN
    parameter  int CNT_W   = 16,
`endif
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [ALU_DW*NUM_REQ-1:0] req_a,
    input  logic [ALU_DW*NUM_REQ-1:0] req_b,
    input  logic [SEL_W*NUM_REQ-1:0]  req_sel,
    output logic [ALU_DW-1:0]         alu_a,
    output logic [ALU_DW-1:0]         alu_b,
    output logic [SEL_W-1:0]          alu_sel,
    input  logic [ALU_OW-1:0]         alu_out,
    input  logic                      alu_zero,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [ALU_OW-1:0]         rsp_out,
    output logic                      rsp_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]          op_count
`endif
);

    state_t              state_q;
    state_t              state_d;
    logic [ID_W-1:0]     last_grant_q;
    logic [NUM_REQ-1:0]  grant_onehot;
    logic [ID_W-1:0]     grant_idx;
    logic                accept;
    logic                rsp_done;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_arbiter (
        .req         (req_valid),
        .last_grant  (last_grant_q),
        .grant_onehot(grant_onehot),
        .grant_idx   (grant_idx)
    );

    // The response leaves on the edge where valid and ready are both high.
    assign rsp_done = rsp_valid && rsp_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before the edge.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and the combinational grant pulse.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = grant_onehot;
                    accept    = 1'b1;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latch the winner's operands, its ID and the new round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_sel      <= '0;
            rsp_id       <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
        end else if (accept) begin
            alu_a        <= req_a[int'(grant_idx)*ALU_DW +: ALU_DW];
            alu_b        <= req_b[int'(grant_idx)*ALU_DW +: ALU_DW];
            alu_sel      <= req_sel[int'(grant_idx)*SEL_W +: SEL_W];
            rsp_id       <= grant_idx;
            last_grant_q <= grant_idx;
        end
    end

    // Capture the ALU result at the end of EXEC and hold it until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_out   <= '0;
            rsp_zero  <= 1'b0;
        end else if (state_q == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_out   <= alu_out;
            rsp_zero  <= alu_zero;
        end else if (rsp_done) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Count completed responses, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (rsp_done && (op_count != {CNT_W{1'b1}})) begin
            op_count <= op_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: reset state, round-robin order,
// response back-pressure, table-driven result capture, asynchronous abort,
// and a randomized run against a transaction-level reference model.
// With ALU_ARB_STATS_EN defined the DUT is built with CNT_W=2 and the
// saturating op_count is checked during the randomized run.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int N    = 4;
    localparam int ID_W = 2;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [4*N-1:0]    req_a;
    logic [4*N-1:0]    req_b;
    logic [3*N-1:0]    req_sel;
    logic [3:0]        alu_a;
    logic [3:0]        alu_b;
    logic [2:0]        alu_sel;
    logic [7:0]        alu_out;
    logic              alu_zero;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [7:0]        rsp_out;
    logic              rsp_zero;
`ifdef ALU_ARB_STATS_EN
    logic [1:0]        op_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    alu_arbiter #(
        .NUM_REQ(N)
`ifdef ALU_ARB_STATS_EN
        , .CNT_W(2)
`endif
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_sel  (req_sel),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_sel  (alu_sel),
        .alu_out  (alu_out),
        .alu_zero (alu_zero),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_out  (rsp_out),
        .rsp_zero (rsp_zero)
`ifdef ALU_ARB_STATS_EN
        , .op_count(op_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: 4-bit operands zero-extended into 8-bit arithmetic.
    function automatic logic [7:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] sel);
        logic [7:0] xa;
        logic [7:0] xb;
        xa = {4'b0, a};
        xb = {4'b0, b};
        case (sel)
            OP_ADD:  return xa + xb;
            OP_SUB:  return xa - xb;
            OP_MUL:  return xa * xb;
            OP_AND:  return xa & xb;
            OP_OR:   return xa | xb;
            OP_NOT:  return {4'b0, ~a};
            OP_INC:  return xa + 8'd1;
            default: return xa - 8'd1;
        endcase
    endfunction

    assign alu_out  = ref_alu(alu_a, alu_b, alu_sel);
    assign alu_zero = (alu_out == 8'h00);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_op(input int id, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] sel);
        req_a[id*4 +: 4]   = a;
        req_b[id*4 +: 4]   = b;
        req_sel[id*3 +: 3] = sel;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
        check({tag, "_alu_a"},     32'(alu_a),     0);
        check({tag, "_alu_b"},     32'(alu_b),     0);
        check({tag, "_alu_sel"},   32'(alu_sel),   0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_id"},    32'(rsp_id),    0);
        check({tag, "_rsp_out"},   32'(rsp_out),   0);
        check({tag, "_rsp_zero"},  32'(rsp_zero),  0);
    endtask

    // Drop all requests and let any in-flight operation complete.
    task automatic drain();
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    typedef struct {
        int         id;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] sel;
        logic [7:0] out;
        logic       zero;
    } vec_t;

    // Single isolated operation: grant pulse, registered operands, response.
    task automatic run_single(input vec_t v, input int k);
        @(posedge clk); #1;
        set_op(v.id, v.a, v.b, v.sel);
        req_valid = N'(1) << v.id;
        rsp_ready = 1'b1;
        @(negedge clk);
        check($sformatf("vec%0d_ready", k), 32'(req_ready), 32'(N'(1) << v.id));
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check($sformatf("vec%0d_alu_a", k), 32'(alu_a), 32'(v.a));
        check($sformatf("vec%0d_alu_b", k), 32'(alu_b), 32'(v.b));
        check($sformatf("vec%0d_alu_sel", k), 32'(alu_sel), 32'(v.sel));
        check($sformatf("vec%0d_early_valid", k), 32'(rsp_valid), 0);
        @(negedge clk);
        check($sformatf("vec%0d_rsp_valid", k), 32'(rsp_valid), 1);
        check($sformatf("vec%0d_rsp_id", k), 32'(rsp_id), 32'(v.id));
        check($sformatf("vec%0d_rsp_out", k), 32'(rsp_out), 32'(v.out));
        check($sformatf("vec%0d_rsp_zero", k), 32'(rsp_zero), 32'(v.zero));
    endtask

    initial begin
        vec_t vecs[9];
        int   gidx[$];
        int   gcyc[$];
        int   exp_order[6];
        bit   seen;

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sel   = '0;
        rsp_ready = 1'b0;

        // ---------------- reset state ----------------
        #3;
        check_all_zero("reset");
`ifdef ALU_ARB_STATS_EN
        check("reset_op_count", 32'(op_count), 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ---------------- round-robin order from reset ----------------
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) set_op(i, 4'(i), 4'd1, OP_ADD);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 40 && gidx.size() < 6; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                check("rr_onehot", 32'($onehot(req_ready)), 1);
                gidx.push_back(onehot_idx(req_ready));
                gcyc.push_back(c);
            end
        end
        check("rr_grant_count", 32'(gidx.size()), 6);
        exp_order = '{0, 1, 2, 3, 0, 1};
        for (int k = 0; k < gidx.size(); k++) begin
            check($sformatf("rr_order%0d", k), 32'(gidx[k]), 32'(exp_order[k]));
            if (k > 0) check($sformatf("rr_interval%0d", k), 32'(gcyc[k] - gcyc[k-1]), 3);
        end
        drain();

        // ---------------- response back-pressure ----------------
        // Pointer now sits on requester 1, so requester 2 wins (2 + 1 = 3).
        req_valid = '1;
        rsp_ready = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        check("stall_rsp_seen", 32'(seen), 1);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            check("stall_valid", 32'(rsp_valid), 1);
            check("stall_id",    32'(rsp_id),    2);
            check("stall_out",   32'(rsp_out),   3);
            check("stall_zero",  32'(rsp_zero),  0);
            check("stall_ready", 32'(req_ready), 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("hs_cycle_no_grant", 32'(req_ready), 0);
        @(negedge clk);
        check("post_hs_grant", 32'(req_ready), 32'(4'b1000));
        drain();

        // ---------------- table-driven result capture ----------------
        vecs[0] = '{id: 2, a: 4'h3, b: 4'h1, sel: OP_ADD, out: 8'h04, zero: 1'b0};
        vecs[1] = '{id: 1, a: 4'h5, b: 4'h5, sel: OP_SUB, out: 8'h00, zero: 1'b1};
        vecs[2] = '{id: 3, a: 4'hF, b: 4'hF, sel: OP_MUL, out: 8'hE1, zero: 1'b0};
        vecs[3] = '{id: 0, a: 4'hC, b: 4'hA, sel: OP_AND, out: 8'h08, zero: 1'b0};
        vecs[4] = '{id: 1, a: 4'hC, b: 4'h3, sel: OP_OR,  out: 8'h0F, zero: 1'b0};
        vecs[5] = '{id: 2, a: 4'h5, b: 4'h0, sel: OP_NOT, out: 8'h0A, zero: 1'b0};
        vecs[6] = '{id: 0, a: 4'hF, b: 4'h0, sel: OP_INC, out: 8'h10, zero: 1'b0};
        vecs[7] = '{id: 3, a: 4'h0, b: 4'h0, sel: OP_DEC, out: 8'hFF, zero: 1'b0};
        vecs[8] = '{id: 1, a: 4'h3, b: 4'h5, sel: OP_SUB, out: 8'hFE, zero: 1'b0};
        for (int k = 0; k < 9; k++) run_single(vecs[k], k);
        drain();

        // ---------------- asynchronous abort during EXEC ----------------
        set_op(1, 4'h7, 4'h2, OP_SUB);
        req_valid = 4'b0010;
        @(negedge clk);
        check("abort_grant", 32'(req_ready), 32'(4'b0010));
        @(posedge clk); #1;
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("abort_no_rsp", 32'(seen), 0);
        @(posedge clk); #1;
        req_valid = '1;
        @(negedge clk);
        check("abort_first_grant", 32'(req_ready), 32'(4'b0001));
        drain();

        // ---------------- randomized run against reference model ----------------
        begin
            logic [3:0] pa[N];
            logic [3:0] pb[N];
            logic [2:0] ps[N];
            bit         pv[N];
            bit         granted[N];
            bit         busy;
            int         age;
            int         last;
            int         cnt;
            int         exp_id;
            logic [3:0] ea;
            logic [3:0] eb;
            logic [2:0] es;
            logic [7:0] eout;
            logic [N-1:0] exp_ready;

            @(negedge clk);
            rst_n = 1'b0;
            req_valid = '0;
            @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < N; i++) begin
                pv[i] = 1'b0;
                granted[i] = 1'b0;
                pa[i] = '0;
                pb[i] = '0;
                ps[i] = '0;
            end
            busy = 1'b0;
            age  = 0;
            last = N - 1;
            cnt  = 0;
            exp_id = 0;
            ea = '0; eb = '0; es = '0; eout = '0;

            for (int cyc = 0; cyc < 800; cyc++) begin
                @(posedge clk); #1;
                for (int i = 0; i < N; i++) begin
                    if (granted[i]) pv[i] = 1'b0;
                    granted[i] = 1'b0;
                    if (pv[i]) begin
                        if ($urandom_range(0, 15) == 0) pv[i] = 1'b0;
                    end else if ($urandom_range(0, 3) == 0) begin
                        pv[i] = 1'b1;
                        pa[i] = 4'($urandom);
                        pb[i] = 4'($urandom);
                        ps[i] = 3'($urandom);
                    end
                    req_valid[i] = pv[i];
                    set_op(i, pa[i], pb[i], ps[i]);
                end
                rsp_ready = ($urandom_range(0, 3) != 0);

                @(negedge clk);
`ifdef ALU_ARB_STATS_EN
                check("rnd_op_count", 32'(op_count), (cnt > 3) ? 3 : cnt);
`endif
                if (busy) begin
                    age++;
                    check("rnd_ready_busy", 32'(req_ready), 0);
                    check("rnd_alu_a",   32'(alu_a),   32'(ea));
                    check("rnd_alu_b",   32'(alu_b),   32'(eb));
                    check("rnd_alu_sel", 32'(alu_sel), 32'(es));
                    if (age == 1) begin
                        check("rnd_exec_valid", 32'(rsp_valid), 0);
                    end else begin
                        check("rnd_rsp_valid", 32'(rsp_valid), 1);
                        check("rnd_rsp_id",    32'(rsp_id),    32'(exp_id));
                        check("rnd_rsp_out",   32'(rsp_out),   32'(eout));
                        check("rnd_rsp_zero",  32'(rsp_zero),  32'(eout == 8'h00));
                        if (rsp_ready) begin
                            busy = 1'b0;
                            cnt++;
                        end
                    end
                end else begin
                    exp_ready = '0;
                    for (int k = 1; k <= N; k++) begin
                        int cand;
                        cand = (last + k) % N;
                        if (exp_ready == '0 && pv[cand]) begin
                            exp_ready[cand] = 1'b1;
                            exp_id = cand;
                        end
                    end
                    check("rnd_ready_idle", 32'(req_ready), 32'(exp_ready));
                    if (exp_ready != '0) begin
                        busy = 1'b1;
                        age  = 0;
                        last = exp_id;
                        granted[exp_id] = 1'b1;
                        ea   = pa[exp_id];
                        eb   = pb[exp_id];
                        es   = ps[exp_id];
                        eout = ref_alu(ea, eb, es);
                    end
                end
            end
            check("rnd_some_ops_done", 32'(cnt > 20), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
